// File: rtl/fifo_burst_writer.sv
// Write-side burst producer for the async FIFO: turns burst commands into
// winc/wdata pattern streams, honours wfull and keeps write/stall statistics.
module fifo_burst_writer #(
    parameter int unsigned         DATASIZE  = 8,
    parameter int unsigned         LENW      = 8,
    parameter logic [DATASIZE-1:0] LFSR_TAPS = DATASIZE'(8'hB8)
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LENW-1:0]     cmd_len,
    input  logic [1:0]          cmd_mode,
    input  logic [DATASIZE-1:0] cmd_seed,
    input  logic                abort,
    output logic                winc,
    output logic [DATASIZE-1:0] wdata,
    input  logic                wfull,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [31:0]         words_total,
    output logic [15:0]         stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LENW-1:0]     remaining_q, remaining_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATASIZE-1:0] wdata_q, wdata_d;
    logic                aborted_q, aborted_d;
    logic [31:0]         words_total_q, words_total_d;
    logic [15:0]         stall_cnt_q, stall_cnt_d;
    logic                accept;

    // Next word of the selected data pattern
    function automatic logic [DATASIZE-1:0] next_word(input logic [1:0]          mode,
                                                      input logic [DATASIZE-1:0] w);
        case (mode)
            2'd0:    return w + DATASIZE'(1);
            2'd1:    return w;
            2'd2:    return {w[DATASIZE-2:0], ^(w & LFSR_TAPS)};
            default: return {w[DATASIZE-2:0], w[DATASIZE-1]};
        endcase
    endfunction

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q       <= IDLE;
            remaining_q   <= '0;
            mode_q        <= '0;
            wdata_q       <= '0;
            aborted_q     <= 1'b0;
            words_total_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            mode_q        <= mode_d;
            wdata_q       <= wdata_d;
            aborted_q     <= aborted_d;
            words_total_q <= words_total_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        mode_d        = mode_q;
        wdata_d       = wdata_q;
        aborted_d     = aborted_q;
        words_total_d = words_total_q;
        stall_cnt_d   = stall_cnt_q;
        accept        = (state_q == WRITE) && !wfull;

        if (accept) begin
            words_total_d = words_total_q + 32'd1;
        end
        if ((state_q == WRITE) && wfull && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                aborted_d = 1'b0;
                if (cmd_valid) begin
                    remaining_d = cmd_len;
                    mode_d      = cmd_mode;
                    // An all-zero seed would lock up the LFSR and walking-one patterns
                    wdata_d     = (cmd_mode[1] && (cmd_seed == '0)) ? DATASIZE'(1) : cmd_seed;
                    state_d     = (cmd_len != '0) ? WRITE : DONE;
                end
            end
            WRITE: begin
                if (accept) begin
                    remaining_d = remaining_q - LENW'(1);
                    wdata_d     = next_word(mode_q, wdata_q);
                end
                // A final accept wins over a simultaneous abort
                if (accept && (remaining_q == LENW'(1))) begin
                    state_d = DONE;
                end else if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end
            end
            DONE: begin
                aborted_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready   = (state_q == IDLE);
    assign winc        = (state_q == WRITE);
    assign busy        = (state_q == WRITE);
    assign done        = (state_q == DONE);
    assign wdata       = wdata_q;
    assign aborted     = aborted_q;
    assign words_total = words_total_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Directed bench for fifo_burst_writer: expected words are queued when a
// command is issued and compared as the writer presents/commits them.
module tb_fifo_burst_writer;

    logic        wclk;
    logic        wrst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic [1:0]  cmd_mode;
    logic [7:0]  cmd_seed;
    logic        abort;
    logic        winc;
    logic [7:0]  wdata;
    logic        wfull;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] words_total;
    logic [15:0] stall_cnt;

    int          checks;
    int          errors;
    logic [7:0]  sb[$];
    logic        done_evt;
    logic        aborted_evt;
    int          done_count;

    fifo_burst_writer #(
        .DATASIZE (8),
        .LENW     (8),
        .LFSR_TAPS(8'hB8)
    ) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .cmd_mode   (cmd_mode),
        .cmd_seed   (cmd_seed),
        .abort      (abort),
        .winc       (winc),
        .wdata      (wdata),
        .wfull      (wfull),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .words_total(words_total),
        .stall_cnt  (stall_cnt)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference pattern generator
    function automatic logic [7:0] model_next(input logic [1:0] mode, input logic [7:0] w);
        logic [7:0] taps;
        taps = 8'hB8;
        case (mode)
            2'd0:    model_next = w + 8'd1;
            2'd1:    model_next = w;
            2'd2:    model_next = {w[6:0], ^(w & taps)};
            default: model_next = {w[6:0], w[7]};
        endcase
    endfunction

    task automatic push_burst(input logic [7:0] len, input logic [1:0] mode, input logic [7:0] seed);
        logic [7:0] w;
        w = seed;
        if (mode >= 2'd2 && w == 8'd0) w = 8'd1;
        for (int i = 0; i < int'(len); i++) begin
            sb.push_back(w);
            w = model_next(mode, w);
        end
    endtask

    // One clock: observe at the falling edge, then step past the rising edge
    task automatic tick();
        @(negedge wclk);
        done_evt    = done;
        aborted_evt = aborted;
        if (done) done_count++;
        if (wrst_n && winc) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                if (wfull) check("stall_hold", 32'(wdata), 32'(sb[0]));
                else       check("wdata", 32'(wdata), 32'(sb.pop_front()));
            end
        end
        @(posedge wclk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] len, input logic [1:0] mode, input logic [7:0] seed);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        push_burst(len, mode, seed);
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_mode  = mode;
        cmd_seed  = seed;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output int n);
        n        = 0;
        done_evt = 1'b0;
        while (!done_evt && n < max_cycles) begin
            tick();
            n++;
        end
        check("done_seen", 32'(done_evt), 32'd1);
    endtask

    initial begin
        int n;
        int dc;
        checks     = 0;
        errors     = 0;
        done_count = 0;
        wrst_n     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_len    = 8'd0;
        cmd_mode   = 2'd0;
        cmd_seed   = 8'd0;
        abort      = 1'b0;
        wfull      = 1'b0;

        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_winc", 32'(winc), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_words", words_total, 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        tick();

        // Increment burst
        send_cmd(8'd5, 2'd0, 8'h10);
        check("inc_busy", 32'(busy), 32'd1);
        wait_done(20, n);
        check("inc_done_latency", 32'(n), 32'd6);
        check("inc_aborted", 32'(aborted_evt), 32'd0);
        tick();
        check("inc_done_one_cycle", 32'(done_evt), 32'd0);
        check("inc_words", words_total, 32'd5);
        check("inc_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure after the 2nd accept
        send_cmd(8'd4, 2'd0, 8'hFE);
        tick();
        tick();
        wfull = 1'b1;
        tick();
        tick();
        tick();
        check("bp_winc_held", 32'(winc), 32'd1);
        wfull = 1'b0;
        wait_done(20, n);
        check("bp_done_latency", 32'(n), 32'd3);
        check("bp_stall", 32'(stall_cnt), 32'd3);
        check("bp_words", words_total, 32'd9);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // LFSR from zero seed, then walking-one
        send_cmd(8'd3, 2'd2, 8'h00);
        wait_done(20, n);
        check("lfsr_done_latency", 32'(n), 32'd4);
        tick();
        send_cmd(8'd3, 2'd3, 8'h80);
        wait_done(20, n);
        check("walk_done_latency", 32'(n), 32'd4);
        tick();
        check("pat_words", words_total, 32'd15);
        check("pat_sb_empty", 32'(sb.size()), 32'd0);

        // Zero-length burst
        send_cmd(8'd0, 2'd0, 8'h33);
        check("zero_winc", 32'(winc), 32'd0);
        wait_done(5, n);
        check("zero_done_latency", 32'(n), 32'd1);
        check("zero_aborted", 32'(aborted_evt), 32'd0);
        tick();

        // Abort coinciding with the 4th accept of a len=10 burst
        send_cmd(8'd10, 2'd0, 8'h20);
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(5, n);
        check("abort_done_latency", 32'(n), 32'd1);
        check("abort_aborted", 32'(aborted_evt), 32'd1);
        check("abort_words", words_total, 32'd19);
        check("abort_left", 32'(sb.size()), 32'd6);
        sb.delete();
        tick();
        check("abort_cleared", 32'(aborted), 32'd0);

        // Abort on the final accept completes normally
        send_cmd(8'd2, 2'd1, 8'h5A);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(5, n);
        check("lastabort_aborted", 32'(aborted_evt), 32'd0);
        check("lastabort_words", words_total, 32'd21);
        check("lastabort_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // Reset during the 3rd write of a len=8 burst
        send_cmd(8'd8, 2'd0, 8'h40);
        tick();
        tick();
        check("mid_winc", 32'(winc), 32'd1);
        check("mid_words", words_total, 32'd23);
        dc     = done_count;
        wrst_n = 1'b0;
        #1;
        check("mr_winc", 32'(winc), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mr_wdata", 32'(wdata), 32'd0);
        check("mr_words", words_total, 32'd0);
        check("mr_stall", 32'(stall_cnt), 32'd0);
        tick();
        tick();
        wrst_n = 1'b1;
        sb.delete();
        tick();
        tick();
        tick();
        check("mr_no_done", 32'(done_count), 32'(dc));
        check("mr_ready_after", 32'(cmd_ready), 32'd1);
        check("mr_winc_after", 32'(winc), 32'd0);

        // Back-to-back commands with cmd_valid held high
        push_burst(8'd2, 2'd0, 8'h30);
        cmd_valid = 1'b1;
        cmd_len   = 8'd2;
        cmd_mode  = 2'd0;
        cmd_seed  = 8'h30;
        tick();
        push_burst(8'd2, 2'd0, 8'hA0);
        cmd_seed = 8'hA0;
        tick();
        check("b2b_ready_write", 32'(cmd_ready), 32'd0);
        tick();
        check("b2b_ready_done", 32'(cmd_ready), 32'd0);
        check("b2b_done", 32'(done), 32'd1);
        tick();
        check("b2b_ready_idle", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("b2b_second_winc", 32'(winc), 32'd1);
        check("b2b_second_wdata", 32'(wdata), 32'hA0);
        check("b2b_ready_second", 32'(cmd_ready), 32'd0);
        wait_done(10, n);
        check("b2b_done_latency", 32'(n), 32'd3);
        check("b2b_words", words_total, 32'd4);
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_burst_writer.md
Name: fifo_burst_writer

Overview:
- Write-side producer for the asynchronous FIFO, running entirely in the wclk domain.
- Accepts burst commands and generates data words in one of four patterns.
- Drives winc/wdata into the FIFO write port and honours wfull backpressure.
- Reports burst completion and keeps write and stall statistics for bring-up and bandwidth checks.

Parameters:
DATASIZE, 8, width of wdata; matches the FIFO data width.
LENW, 8, width of the burst length field.
LFSR_TAPS, 8'hB8, feedback tap mask for the LFSR pattern; DATASIZE bits wide.

Ports:
wclk  in  1  write-domain clock
wrst_n  in  1  write-domain reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  writer can take a command
cmd_len  in  LENW  number of words in the burst; 0 = empty burst
cmd_mode  in  2  pattern: 0 increment, 1 constant, 2 LFSR, 3 walking-one
cmd_seed  in  DATASIZE  first data word
abort  in  1  synchronous burst abort
winc  out  1  FIFO write request
wdata  out  DATASIZE  FIFO write data
wfull  in  1  FIFO full flag (registered, wclk domain)
busy  out  1  burst in progress
done  out  1  one-cycle burst-complete pulse
aborted  out  1  qualifies done; burst ended by abort
words_total  out  32  accepted words since reset
stall_cnt  out  16  cycles with winc=1 and wfull=1

Behaviour:
- Reset: wrst_n is asynchronous, active-low; clock is wclk. All flops are posedge wclk with async clear on negedge wrst_n.
- Reset values: state=IDLE, cmd_ready=1, winc=0, wdata=0, busy=0, done=0, aborted=0, words_total=0, stall_cnt=0.
- Accept condition: a word is accepted on any wclk edge where winc=1 and wfull=0. This matches the FIFO write qualification.
- Stalls: while wfull=1, winc stays high and wdata holds stable. The write is not dropped.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid=1: latch cmd_len into remaining, latch mode, load wdata from the seed.
  - Seed 0 is replaced by 1 in modes 2 and 3.
  - Next state is WRITE if cmd_len≠0, otherwise DONE.
- WRITE:
  - winc=1, busy=1, cmd_ready=0.
  - On accept: remaining-=1 and wdata advances to the next pattern value.
  - Accept with remaining==1 → DONE; winc is low in the following cycle.
- DONE: done=1 for exactly one cycle, busy=0, then → IDLE. aborted holds its value for that cycle and clears in IDLE.
- winc and busy decode combinationally from the state register, so they drop immediately on async reset.
- Pattern advance, all arithmetic modulo 2^DATASIZE:
  - Mode 0: wdata+1.
  - Mode 1: unchanged.
  - Mode 2: {wdata[DATASIZE-2:0], ^(wdata & LFSR_TAPS)}.
  - Mode 3: rotate left by 1.
- Abort:
  - abort=1 in WRITE → DONE next edge, with aborted=1.
  - A word accepted on that same edge counts in words_total.
  - If abort and the last accept coincide, the burst is treated as completed normally (aborted=0).
  - abort is ignored in IDLE and DONE.
- Statistics:
  - words_total increments once per accept and wraps at 2^32.
  - stall_cnt increments every WRITE cycle with wfull=1 and saturates at 16'hFFFF.
  - Neither counter clears except on reset.
- Back-to-back commands: a new command is taken only in IDLE. The minimum gap between bursts is 1 cycle (DONE) plus the IDLE accept cycle.
- Reset mid-burst: the FSM returns to IDLE asynchronously. The remaining words are never written and done is not pulsed.
- cmd_len uses full LENW range: 2^LENW−1 words maximum. remaining never underflows.

Test Plan:
- Increment burst: cmd_len=5, mode=0, seed=8'h10, wfull=0 → winc high for 5 consecutive cycles, wdata 10,11,12,13,14; done pulse 1 cycle after last write; words_total=5.
- Backpressure: cmd_len=4, mode=0, seed=8'hFE, wfull=1 for 3 cycles after the 2nd accept → sequence FE,FF,00,01 with 00 held stable through the stall; stall_cnt=3; no word lost or duplicated.
- LFSR and walking-one: mode=2, seed=0, len=3 → 01,02,04 (taps B8 feed 0 at these states); mode=3, seed=8'h80, len=3 → 80,01,02.
- Zero length and abort: cmd_len=0 → done next cycle, no winc. Second burst len=10 with abort asserted after the 4th accept → done with aborted=1, words_total +4.
- Reset mid-burst: drop wrst_n during the 3rd write of a len=8 burst → winc=0 immediately, all outputs at reset values, cmd_ready=1 after release, no done pulse.
- Back-to-back: cmd_valid held high with two len=2 commands → cmd_ready low during WRITE/DONE; second burst starts exactly 2 cycles after the first burst's final accept.
